lfsr_period_meter: RTL and testbench
====================================

LFSR_PERIOD_METER -- requirements
Module: lfsr_period_meter

Interface
REQ-001 Parameter WIDTH, default 8: width of the sampled LFSR value.
REQ-002 Parameter CNT_W, default 16: width of the period counter.
REQ-003 in_clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 in_rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a measurement.
REQ-006 sample_valid  input  1  high when the upstream LFSR produced a new value this cycle.
REQ-007 sample  input  WIDTH  current upstream LFSR value.
REQ-008 busy  output  1  high while a measurement is in progress.
REQ-009 done  output  1  single-cycle pulse when a result is available.
REQ-010 period  output  CNT_W  measured period; held until the next start.
REQ-011 stuck  output  1  result flag: an all-zero sample was seen.
REQ-012 timeout  output  1  result flag: the counter saturated without a repeat.

Function
REQ-013 The FSM SHALL have states IDLE, ARM, COUNT and DONE.
REQ-014 IDLE: busy=0; start=1 SHALL move to ARM and clear period, stuck and timeout.
REQ-015 ARM: busy=1; the first sample_valid cycle SHALL capture sample as ref, set cnt=0 and move to COUNT.
REQ-016 COUNT: each sample_valid cycle SHALL set cnt=cnt+1, and cycles without sample_valid SHALL leave cnt unchanged.
REQ-017 COUNT: a valid sample equal to ref SHALL load period=cnt+1 and move to DONE.
REQ-018 COUNT: a valid non-matching sample arriving when cnt+1 equals 2^CNT_W-1 SHALL set timeout=1, load period=2^CNT_W-1 and move to DONE.
REQ-019 In ARM or COUNT, a valid all-zero sample SHALL set stuck=1, load period=0 and move to DONE.
REQ-020 Priority on the same sample SHALL be stuck, then match, then timeout.
REQ-021 DONE: done=1 and busy=0 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-022 Latency: done SHALL assert in the cycle after the rising edge that accepts the terminating sample.
REQ-023 start SHALL be ignored in ARM, COUNT and DONE; a start in IDLE SHALL be honoured even when sample_valid is high in the same cycle.
REQ-024 Counter arithmetic is unsigned CNT_W-bit; cnt SHALL never wrap.

Reset
REQ-025 in_rst=1 SHALL force IDLE with busy=0, done=0, period=0, stuck=0, timeout=0, cnt=0, ref=0 (and ones_count=0 when present), with priority over all other inputs.
REQ-026 Asserting in_rst mid-measurement SHALL abort it with no done pulse.

Configuration
REQ-027 Macro LFSR_PERIOD_ONES_EN defined: the block SHALL add output ones_count (CNT_W bits), counting valid samples with sample[0]=1 from ref inclusive up to, but not including, the terminating sample; the count SHALL be cleared at start and held with period.
REQ-028 Macro LFSR_PERIOD_ONES_EN undefined: the ones_count port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-029 Upstream 8-bit LFSR with taps 8'hB8 and seed 8'hAA, sample_valid=1 every cycle, then start -> done with period=255, stuck=0, timeout=0, and ones_count=128 when enabled.
REQ-030 Constant sample 8'h5A with start -> period=1, done two valid samples after ARM entry.
REQ-031 Sample 8'h00 as ref or mid-count -> stuck=1, period=0, done pulse.
REQ-032 CNT_W=4, samples 1,2,...,16 -> timeout=1, period=15 on the sample 16 cycle plus one.
REQ-033 sample_valid toggled 1/0 with the 8'hB8 LFSR -> period=255 (gaps not counted).
REQ-034 in_rst pulsed at cnt=100, then start -> all outputs 0, no done pulse; the following measurement is correct and start during busy has no effect.

Source files
------------

// File: rtl/lfsr_period_meter.sv
// ---------------------------------------------------------------------------
// lfsr_period_meter
//
// Measures the repeat period of an upstream LFSR stream. On start the block
// arms, captures the first valid sample as a reference and counts valid
// samples until the reference value reappears. The result is flagged as
// "stuck" when an all-zero sample shows up. It is flagged as "timeout" when
// the counter saturates before a repeat is seen.
//
// Optional feature: define LFSR_PERIOD_ONES_EN to add the ones_count output.
// It counts the valid samples with sample[0]=1, starting at the reference
// sample and stopping before the terminating sample.
//
// Parameters
//   WIDTH        width of the sampled LFSR value
//   CNT_W        width of the period counter / result
// Ports
//   in_clk       clock, rising edge
//   in_rst       synchronous active-high reset
//   start        single-cycle measurement request (honoured in IDLE only)
//   sample_valid upstream produced a new value this cycle
//   sample       upstream LFSR value
//   busy         measurement in progress (ARM or COUNT)
//   done         one-cycle result pulse
//   period       measured period, held until the next start
//   stuck        result flag: all-zero sample seen
//   timeout      result flag: counter saturated without a repeat
//   ones_count   (LFSR_PERIOD_ONES_EN only) ones seen in sample[0]
// ---------------------------------------------------------------------------
module lfsr_period_meter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic             stuck,
    output logic             timeout
`ifdef LFSR_PERIOD_ONES_EN
    ,
    output logic [CNT_W-1:0] ones_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   ref_reg, ref_next;
    logic [CNT_W-1:0]   period_reg, period_next;
    logic               stuck_reg, stuck_next;
    logic               timeout_reg, timeout_next;
`ifdef LFSR_PERIOD_ONES_EN
    logic [CNT_W-1:0]   ones_reg, ones_next;
    logic [CNT_W-1:0]   ones_bit;
`endif

    logic [WIDTH-1:0]   diff_bits;
    logic               sample_zero;
    logic               sample_match;
    logic [CNT_W-1:0]   cnt_inc;

    // Bitwise compare against the captured reference.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cmp
            assign diff_bits[gi] = sample[gi] ^ ref_reg[gi];
        end
    endgenerate

    assign sample_match = ~|diff_bits;
    assign sample_zero  = ~|sample;
    // cnt never reaches CNT_MAX (saturation terminates one step earlier),
    // so this increment cannot wrap.
    assign cnt_inc      = cnt_reg + CNT_ONE;
`ifdef LFSR_PERIOD_ONES_EN
    assign ones_bit     = {{(CNT_W-1){1'b0}}, sample[0]};
`endif

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            ref_reg     <= '0;
            period_reg  <= '0;
            stuck_reg   <= 1'b0;
            timeout_reg <= 1'b0;
`ifdef LFSR_PERIOD_ONES_EN
            ones_reg    <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            ref_reg     <= ref_next;
            period_reg  <= period_next;
            stuck_reg   <= stuck_next;
            timeout_reg <= timeout_next;
`ifdef LFSR_PERIOD_ONES_EN
            ones_reg    <= ones_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        ref_next     = ref_reg;
        period_next  = period_reg;
        stuck_next   = stuck_reg;
        timeout_next = timeout_reg;
`ifdef LFSR_PERIOD_ONES_EN
        ones_next    = ones_reg;
`endif

        case (state_reg)
            IDLE: begin
                // Any sample presented alongside start is not the reference;
                // the reference is the first valid sample seen in ARM.
                if (start) begin
                    state_next   = ARM;
                    period_next  = '0;
                    stuck_next   = 1'b0;
                    timeout_next = 1'b0;
`ifdef LFSR_PERIOD_ONES_EN
                    ones_next    = '0;
`endif
                end
            end

            ARM: begin
                if (sample_valid) begin
                    if (sample_zero) begin
                        stuck_next  = 1'b1;
                        period_next = '0;
                        state_next  = DONE;
                    end else begin
                        ref_next   = sample;
                        cnt_next   = '0;
                        state_next = COUNT;
`ifdef LFSR_PERIOD_ONES_EN
                        ones_next  = ones_bit;
`endif
                    end
                end
            end

            COUNT: begin
                // Checks on one sample run in priority order: stuck, then
                // match, then saturation.
                if (sample_valid) begin
                    if (sample_zero) begin
                        stuck_next  = 1'b1;
                        period_next = '0;
                        state_next  = DONE;
                    end else if (sample_match) begin
                        period_next = cnt_inc;
                        state_next  = DONE;
                    end else if (cnt_inc == CNT_MAX) begin
                        timeout_next = 1'b1;
                        period_next  = CNT_MAX;
                        state_next   = DONE;
                    end else begin
                        cnt_next  = cnt_inc;
`ifdef LFSR_PERIOD_ONES_EN
                        ones_next = ones_reg + ones_bit;
`endif
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg == ARM) || (state_reg == COUNT);
    assign done    = (state_reg == DONE);
    assign period  = period_reg;
    assign stuck   = stuck_reg;
    assign timeout = timeout_reg;
`ifdef LFSR_PERIOD_ONES_EN
    assign ones_count = ones_reg;
`endif

endmodule

// File: tb/tb_lfsr_period_meter.sv
// ---------------------------------------------------------------------------
// tb_lfsr_period_meter
//
// Two instances share the same stimulus: one uses the default CNT_W=16 and
// one uses CNT_W=4, so the small one exercises saturation. A transaction-level
// reference model keeps the history of valid samples seen since ARM for each
// instance. It derives every result from that history: the reference is the
// first entry, the period is the index at which it reappears, and ones is a
// count over the history.
// ---------------------------------------------------------------------------
module tb_lfsr_period_meter;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        start;
    logic        sample_valid;
    logic [7:0]  sample;

    logic        busy_b, done_b, stuck_b, timeout_b;
    logic [15:0] period_b;
    logic        busy_s, done_s, stuck_s, timeout_s;
    logic [3:0]  period_s;
`ifdef LFSR_PERIOD_ONES_EN
    logic [15:0] ones_b;
    logic [3:0]  ones_s;
`endif

    lfsr_period_meter #(.WIDTH(8), .CNT_W(16)) dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .start        (start),
        .sample_valid (sample_valid),
        .sample       (sample),
        .busy         (busy_b),
        .done         (done_b),
        .period       (period_b),
        .stuck        (stuck_b),
        .timeout      (timeout_b)
`ifdef LFSR_PERIOD_ONES_EN
        ,
        .ones_count   (ones_b)
`endif
    );

    lfsr_period_meter #(.WIDTH(8), .CNT_W(4)) dut_small (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .start        (start),
        .sample_valid (sample_valid),
        .sample       (sample),
        .busy         (busy_s),
        .done         (done_s),
        .period       (period_s),
        .stuck        (stuck_s),
        .timeout      (timeout_s)
`ifdef LFSR_PERIOD_ONES_EN
        ,
        .ones_count   (ones_s)
`endif
    );

    always #5 in_clk = ~in_clk;

    int checks   = 0;
    int failures = 0;
    int dn_b     = 0;
    int dn_s     = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 measuring, 2 result pulse
    int         m_ph[2];
    int         m_per[2];
    int         m_stk[2];
    int         m_tmo[2];
    int         maxp[2];
    logic [7:0] hist0[$];
    logic [7:0] hist1[$];

    function automatic int ones_of(input logic [7:0] h[$]);
        int n = 0;
        foreach (h[i]) if (h[i][0]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; m_per[k] = 0; m_stk[k] = 0; m_tmo[k] = 0;
        end
        hist0.delete();
        hist1.delete();
    endtask

    task automatic model_one(input int k, input bit st, input bit sv, input logic [7:0] s);
        logic [7:0] h[$];
        if (k == 0) h = hist0; else h = hist1;
        case (m_ph[k])
            2: m_ph[k] = 0;
            0: if (st) begin
                m_ph[k] = 1; m_per[k] = 0; m_stk[k] = 0; m_tmo[k] = 0;
                h.delete();
            end
            default: if (sv) begin
                if (s == 8'h00) begin
                    m_stk[k] = 1; m_per[k] = 0; m_ph[k] = 2;
                end else if (h.size() > 0 && s == h[0]) begin
                    m_per[k] = h.size(); m_ph[k] = 2;
                end else if (h.size() == maxp[k]) begin
                    m_tmo[k] = 1; m_per[k] = maxp[k]; m_ph[k] = 2;
                end else begin
                    h.push_back(s);
                end
            end
        endcase
        if (k == 0) hist0 = h; else hist1 = h;
    endtask

    // One clock cycle: drive, step model, compare both instances after the edge.
    task automatic cyc(input bit st, input bit sv, input logic [7:0] s, input bit rst = 1'b0);
        @(negedge in_clk);
        in_rst = rst; start = st; sample_valid = sv; sample = s;
        if (rst) model_reset();
        else begin
            model_one(0, st, sv, s);
            model_one(1, st, sv, s);
        end
        @(posedge in_clk);
        #1;
        if (done_b) dn_b++;
        if (done_s) dn_s++;
        check_val("b_busy",    32'(busy_b),    (m_ph[0] == 1) ? 1 : 0);
        check_val("b_done",    32'(done_b),    (m_ph[0] == 2) ? 1 : 0);
        check_val("b_period",  32'(period_b),  m_per[0]);
        check_val("b_stuck",   32'(stuck_b),   m_stk[0]);
        check_val("b_timeout", 32'(timeout_b), m_tmo[0]);
        check_val("s_busy",    32'(busy_s),    (m_ph[1] == 1) ? 1 : 0);
        check_val("s_done",    32'(done_s),    (m_ph[1] == 2) ? 1 : 0);
        check_val("s_period",  32'(period_s),  m_per[1]);
        check_val("s_stuck",   32'(stuck_s),   m_stk[1]);
        check_val("s_timeout", 32'(timeout_s), m_tmo[1]);
`ifdef LFSR_PERIOD_ONES_EN
        check_val("b_ones", 32'(ones_b), ones_of(hist0));
        check_val("s_ones", 32'(ones_s), ones_of(hist1));
`endif
    endtask

    // Start, then feed a fixed valid-every-cycle sequence, then two idle cycles.
    task automatic measure(input logic [7:0] seq[$]);
        cyc(1'b1, 1'b0, 8'h00);
        foreach (seq[i]) cyc(1'b0, 1'b1, seq[i]);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    logic [7:0] lfsr;

    // LFSR measurement; gaps optionally inserted, random start pulses while busy.
    task automatic run_lfsr(input bit gaps, input bit noisy_start, input int budget);
        int  d0;
        bit  sv, st;
        cyc(1'b1, 1'b1, lfsr);
        lfsr = lfsr_next(lfsr);
        d0 = dn_b;
        for (int i = 0; i < budget; i++) begin
            sv = gaps ? (i % 2 == 0) : 1'b1;
            st = noisy_start ? ($urandom_range(0, 7) == 0) : 1'b0;
            if (sv) begin
                cyc(st, 1'b1, lfsr);
                lfsr = lfsr_next(lfsr);
            end else begin
                cyc(st, 1'b0, 8'($urandom_range(0, 255)));
            end
            if (m_ph[0] == 2) break;
        end
        check_val("lfsr_done_cnt", 32'(dn_b - d0), 1);
        check_val("lfsr_period",   32'(period_b), 255);
        check_val("lfsr_stuck",    32'(stuck_b), 0);
        check_val("lfsr_timeout",  32'(timeout_b), 0);
`ifdef LFSR_PERIOD_ONES_EN
        check_val("lfsr_ones",     32'(ones_b), 128);
`endif
        // start during the DONE cycle is ignored
        cyc(1'b1, 1'b1, lfsr);
        check_val("start_in_done_ignored", 32'(busy_b), 0);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq[$];
        int         d0, alpha;
        bit         st, sv, rs;
        logic [7:0] s;

        maxp[0] = 65535;
        maxp[1] = 15;
        model_reset();
        in_rst = 1'b1; start = 1'b0; sample_valid = 1'b0; sample = 8'h00;

        // reset state
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 1'b1, 8'h33, 1'b1);
        cyc(1'b0, 1'b0, 8'h00);
        check_val("rst_period", 32'(period_b), 0);

        // full-period LFSR, valid every cycle
        lfsr = 8'hAA;
        run_lfsr(1'b0, 1'b0, 400);

        // constant sample -> period 1
        d0 = dn_b;
        seq = '{8'h5A, 8'h5A, 8'h5A};
        measure(seq);
        check_val("const_period", 32'(period_b), 1);
        check_val("const_done_cnt", 32'(dn_b - d0), 1);

        // zero as reference
        seq = '{8'h00};
        measure(seq);
        check_val("zero_ref_stuck", 32'(stuck_b), 1);
        check_val("zero_ref_period", 32'(period_b), 0);

        // zero mid-count
        d0 = dn_b;
        seq = '{8'h05, 8'h07, 8'h09, 8'h00};
        measure(seq);
        check_val("zero_mid_stuck", 32'(stuck_b), 1);
        check_val("zero_mid_period", 32'(period_b), 0);
        check_val("zero_mid_done_cnt", 32'(dn_b - d0), 1);

        // saturation on the CNT_W=4 instance; the wide one repeats at 16
        seq.delete();
        for (int i = 1; i <= 16; i++) seq.push_back(8'(i));
        seq.push_back(8'h01);
        measure(seq);
        check_val("small_timeout", 32'(timeout_s), 1);
        check_val("small_period", 32'(period_s), 15);
        check_val("big_repeat_period", 32'(period_b), 16);
        check_val("big_repeat_timeout", 32'(timeout_b), 0);

        // LFSR with valid gaps
        run_lfsr(1'b1, 1'b0, 600);

        // reset mid-measurement at cnt=100
        d0 = dn_b;
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 101; i++) begin
            cyc(1'b0, 1'b1, lfsr);
            lfsr = lfsr_next(lfsr);
        end
        cyc(1'b0, 1'b1, lfsr, 1'b1);
        lfsr = lfsr_next(lfsr);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);
        check_val("abort_no_done", 32'(dn_b - d0), 0);
        check_val("abort_busy", 32'(busy_b), 0);
        check_val("abort_period", 32'(period_b), 0);
        run_lfsr(1'b0, 1'b1, 400);

        // randomized traffic
        alpha = 6;
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 19) == 0);
            sv = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 59) == 0) s = 8'h00;
            else s = 8'($urandom_range(1, alpha));
            cyc(st, sv, s, rs);
            if (i % 100 == 0) alpha = $urandom_range(2, 20);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
